seq_div: RTL and testbench
==========================

// Module: seq_div
// PURPOSE
//  Multi-cycle signed integer divider; the inverse operation of the datapath's multiply ops.
//  Computes Quot = A / B (truncation toward zero) and Rem = A - Quot*B.
//  Uses restoring division, one quotient bit per clock.
//  Sits beside the multiplier units in the ALU and is driven by a Start/Done handshake.
// PARAMETERS
//  n    8    operand/result width in bits (two's complement); legal n >= 2
// PORTS
//  clk      in   1  single clock; all state on rising edge
//  reset    in   1  asynchronous, active-high reset
//  Start    in   1  request; sampled only while Busy==0
//  A        in   n  signed dividend, captured on the accepting edge
//  B        in   n  signed divisor, captured on the accepting edge
//  Busy     out  1  high from the edge after acceptance until Done deasserts
//  Done     out  1  one-cycle pulse; Quot, Rem and DivZero are valid
//  Quot     out  n  signed quotient; held until the next Done
//  Rem      out  n  signed remainder (only with DIV_REM_EN)
//  DivZero  out  1  set with Done when B==0; held until the next Done
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; Busy, Done, Quot, Rem, DivZero, count and work regs = 0.
//  - States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE:
//    - Start=1 and B!=0: latch |A|, |B|, sign flags sA and sB; count=n-1; go to CALC.
//    - Start=1 and B==0: go to DONE with Quot='1 (-1), Rem=A, DivZero=1.
//  - CALC, one step per edge:
//    - rem = {rem[n-2:0], dvd[msb]}; shift dvd left.
//    - If rem >= |B|, subtract |B| and set q bit = 1.
//    - Leave for FIX when count==0; otherwise decrement count.
//  - FIX: Quot = (sA^sB) ? -q : q; Rem = sA ? -rem : rem.
//    Register the outputs and DivZero=0, then go to DONE.
//  - DONE: Done=1 for exactly one cycle, then IDLE. Busy=1 in CALC, FIX and DONE.
//  - Latency: Start accepted at edge 0; Done high after edge n+1 (n=8: 9 cycles).
//    The divide-by-zero path: Done high after edge 0 (1 cycle).
//  - Start while Busy=1 is ignored; there is no queueing. Start held high in the Done cycle is not
//    accepted until IDLE (next cycle).
//  - A, B changing after acceptance has no effect.
//  - Magnitudes use n-bit unsigned working regs, so |-2^(n-1)| fits.
//  - Overflow -2^(n-1) / -1 yields Quot = -2^(n-1) (wraps), Rem=0, DivZero=0.
//  - Quot and Rem are not cleared on Start; they hold the previous result until the next FIX/DONE update.
// CONFIGURATION
//  - `define DIV_REM_EN: Rem port, remainder sign fix and Rem register are present.
//  - Without DIV_REM_EN: no Rem port, no Rem register. The remainder work reg is still used internally.
//    All latencies are unchanged.
// STRUCTURE
//  - Package div_pkg: typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t.
//    It also holds the function abs_n(), which returns the n-bit unsigned magnitude.
//  - Sub-module div_step #(n): combinational single restoring step.
//    In: rem, next dividend bit, divisor. Out: new rem, quotient bit.
//    It is instantiated once inside seq_div.
// TESTING  (n=8 unless noted)
//  - A=100, B=7, Start pulse -> Busy next cycle; Done after 9 cycles; Quot=14, Rem=2, DivZero=0.
//  - A=-100, B=7 -> Quot=-14 (8'hF2), Rem=-2 (8'hFE).
//    A=100, B=-7 -> Quot=-14, Rem=2.
//  - A=7, B=0 -> Done after 1 cycle; Quot=8'hFF, Rem=7, DivZero=1.
//    A following op 9/3 -> DivZero=0, Quot=3, Rem=0.
//  - A=-128, B=-1 -> Quot=8'h80, Rem=0. A=-128, B=1 -> Quot=8'h80, Rem=0.
//  - Start pulsed with A=50, B=5 in cycle 3 of a busy 100/7 op -> ignored; 100/7 result unchanged.
//    Reset asserted mid-CALC -> all outputs 0 immediately (async); a new 20/6 op then gives Quot=3, Rem=2.
//  - Rebuild without DIV_REM_EN -> no Rem port; 100/7 still gives Quot=14 at the same latency.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Operand widths up to ABS_W bits are supported by abs_n().
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  localparam int ABS_W = 64;

  // Callers sign-extend to ABS_W and truncate the result back to n bits.
  // Truncation keeps |-2^(n-1)| = 2^(n-1), which fits in n unsigned bits.
  function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] v);
    return v[ABS_W-1] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/seq_div_if.sv
// Start/Done handshake and operand/result bus of the sequential divider.
// Rem is present only when DIV_REM_EN is defined.
interface seq_div_if #(parameter int n = 8);

  logic         Start;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         Busy;
  logic         Done;
  logic [n-1:0] Quot;
`ifdef DIV_REM_EN
  logic [n-1:0] Rem;
`endif
  logic         DivZero;

`ifdef DIV_REM_EN
  modport master (output Start, A, B, input Busy, Done, Quot, Rem, DivZero);
  modport slave  (input Start, A, B, output Busy, Done, Quot, Rem, DivZero);
`else
  modport master (output Start, A, B, input Busy, Done, Quot, DivZero);
  modport slave  (input Start, A, B, output Busy, Done, Quot, DivZero);
`endif

endinterface

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit
// and subtract the divisor when the partial remainder allows it.
module div_step #(parameter int n = 8) (
  input  logic [n-1:0] rem_i,
  input  logic         bit_i,
  input  logic [n-1:0] dvs_i,
  output logic [n-1:0] rem_o,
  output logic         q_o
);

  logic [n-1:0] shifted;

  always_comb begin
    shifted = {rem_i[n-2:0], bit_i};
    rem_o   = shifted;
    q_o     = 1'b0;
    if (shifted >= dvs_i) begin
      rem_o = shifted - dvs_i;
      q_o   = 1'b1;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed divider (truncating), one quotient bit per clock.
// Define DIV_REM_EN to get the Rem output and its sign-corrected register.
module seq_div
  import div_pkg::*;
#(
  parameter int n = 8
) (
  input logic      clk,
  input logic      reset,
  seq_div_if.slave bus
);

  localparam int CW = $clog2(n);

  div_state_t   state_q, state_d;
  logic [CW-1:0] count_q;
  logic [n-1:0] dvd_q;
  logic [n-1:0] rem_wk_q;
  logic [n-1:0] dvs_q;
  logic [n-1:0] quot_q;
  logic         sa_q, sb_q;
  logic         divzero_q;
`ifdef DIV_REM_EN
  logic [n-1:0] rem_q;
`endif

  logic [n-1:0] step_rem;
  logic         step_q;
  logic [n-1:0] abs_a, abs_b;

  assign abs_a = n'(abs_n(ABS_W'(signed'(bus.A))));
  assign abs_b = n'(abs_n(ABS_W'(signed'(bus.B))));

  div_step #(.n(n)) u_step (
    .rem_i (rem_wk_q),
    .bit_i (dvd_q[n-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.Start) state_d = (bus.B == '0) ? DONE : CALC;
      CALC: if (count_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy = (state_q != IDLE);
    bus.Done = (state_q == DONE);
  end

  // Quotient bits shift into the bottom of dvd_q as dividend bits leave the top,
  // so after n steps dvd_q holds the unsigned quotient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      dvd_q     <= '0;
      rem_wk_q  <= '0;
      dvs_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      quot_q    <= '0;
      divzero_q <= 1'b0;
`ifdef DIV_REM_EN
      rem_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            if (bus.B == '0) begin
              quot_q    <= '1;
              divzero_q <= 1'b1;
`ifdef DIV_REM_EN
              rem_q     <= bus.A;
`endif
            end else begin
              dvd_q    <= abs_a;
              dvs_q    <= abs_b;
              rem_wk_q <= '0;
              sa_q     <= bus.A[n-1];
              sb_q     <= bus.B[n-1];
              count_q  <= CW'(n-1);
            end
          end
        end
        CALC: begin
          rem_wk_q <= step_rem;
          dvd_q    <= {dvd_q[n-2:0], step_q};
          if (count_q != '0) count_q <= count_q - CW'(1);
        end
        FIX: begin
          quot_q    <= (sa_q ^ sb_q) ? -dvd_q : dvd_q;
          divzero_q <= 1'b0;
`ifdef DIV_REM_EN
          rem_q     <= sa_q ? -rem_wk_q : rem_wk_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.Quot    = quot_q;
  assign bus.DivZero = divzero_q;
`ifdef DIV_REM_EN
  assign bus.Rem     = rem_q;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (n=8): directed cases plus random operands
// compared against integer division computed in the bench.
module tb_seq_div;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] hold_quot = 8'h00;

  always #5 clk = ~clk;

  seq_div_if #(.n(N)) bus ();

  seq_div #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; if poke_at >= 0, a stray Start with 50/5 is pulsed
  // at that many cycles into the busy period and must be ignored.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int poke_at);
    int ia, ib, iq, ir, lat, elat;
    logic [7:0] eq, er;
    logic ez;
    ia = $signed(a);
    ib = $signed(b);
    if (ib == 0) begin
      iq = -1; ir = ia; ez = 1'b1; elat = 0;
    end else begin
      iq = ia / ib; ir = ia - iq * ib; ez = 1'b0; elat = N + 1;
    end
    eq = iq[7:0];
    er = ir[7:0];

    @(negedge clk);
    bus.Start = 1'b1; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.A = 8'($urandom); bus.B = 8'($urandom);
    check("busy_after_accept", 32'(bus.Busy), 32'd1);
    if (ib != 0) check("quot_held_on_start", 32'(bus.Quot), 32'(hold_quot));
    lat = 0;
    while (!bus.Done && lat < 30) begin
      if (lat == poke_at) begin
        bus.Start = 1'b1; bus.A = 8'd50; bus.B = 8'd5;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.Start = 1'b0;
    check("done_latency", 32'(lat), 32'(elat));
    check("quot", 32'(bus.Quot), 32'(eq));
    check("divzero", 32'(bus.DivZero), 32'(ez));
`ifdef DIV_REM_EN
    check("rem", 32'(bus.Rem), 32'(er));
`endif
    @(negedge clk);
    check("done_one_cycle", 32'(bus.Done), 32'd0);
    check("idle_not_busy", 32'(bus.Busy), 32'd0);
    check("quot_hold", 32'(bus.Quot), 32'(eq));
    hold_quot = eq;
  endtask

  initial begin
    bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_quot", 32'(bus.Quot), 32'd0);
    check("rst_divzero", 32'(bus.DivZero), 32'd0);
`ifdef DIV_REM_EN
    check("rst_rem", 32'(bus.Rem), 32'd0);
`endif
    reset = 1'b0;

    do_op(8'd100, 8'd7, -1);
    do_op(8'(-100), 8'd7, -1);
    do_op(8'd100, 8'(-7), -1);
    do_op(8'd7, 8'd0, -1);
    do_op(8'd9, 8'd3, -1);
    do_op(8'h80, 8'hFF, -1);
    do_op(8'h80, 8'd1, -1);
    do_op(8'd100, 8'd7, 2);

    // Async reset in the middle of CALC.
    @(negedge clk);
    bus.Start = 1'b1; bus.A = 8'd100; bus.B = 8'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset_busy", 32'(bus.Busy), 32'd0);
    check("midreset_done", 32'(bus.Done), 32'd0);
    check("midreset_quot", 32'(bus.Quot), 32'd0);
    check("midreset_divzero", 32'(bus.DivZero), 32'd0);
`ifdef DIV_REM_EN
    check("midreset_rem", 32'(bus.Rem), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    hold_quot = 8'h00;
    do_op(8'd20, 8'd6, -1);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      do_op(ra, rb, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
